// File: rtl/dram_read_master.sv
`default_nettype none
// ============================================================================
// Module   : dram_read_master
// Brief    : Single-outstanding AXI4 read master. It accepts one read request
//            (byte address + beat count), splits it at a 4 KB boundary into
//            at most two INCR bursts, and streams the returned beats to the
//            consumer one cycle after each R handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dram_read_master #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
) (
    input  logic                       clk_pixel,
    input  logic                       dram_read_master_reset,

    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_error,

    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,

    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    // 16-byte beats, incrementing bursts, OKAY response code
    localparam logic [2:0] C_ARSIZE    = 3'b100;
    localparam logic [1:0] C_ARBURST   = 2'b01;
    localparam logic [1:0] C_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AR2  = 3'd3,
        ST_R2   = 3'd4
    } state_t;

    state_t                     state_q,      state_d;
    logic [DRAM_ADDR_WIDTH-1:0] araddr_q,     araddr_d;
    logic [7:0]                 arlen_q,      arlen_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr2_q,      addr2_d;
    logic [7:0]                 len2_q,       len2_d;
    logic                       split_q,      split_d;
    logic [7:0]                 beat_cnt_q,   beat_cnt_d;
    logic [DRAM_DATA_WIDTH-1:0] data_q,       data_d;
    logic                       data_valid_q, data_valid_d;
    logic                       error_q,      error_d;

    // Request decode: beat-align the address and work out the 4 KB split.
    // addr[11:4] is the beat index within the current 4 KB page; the beats
    // left in the page ("room") are 256 minus that index.
    logic [DRAM_ADDR_WIDTH-1:0] w_aligned;
    logic [8:0]                 w_room;
    logic [7:0]                 w_room_lo;
    logic [7:0]                 w_first_len;
    logic [7:0]                 w_second_len;
    logic                       w_fits;
    logic [DRAM_ADDR_WIDTH-1:0] w_addr2;
    logic                       w_last_by_cnt;

    assign w_aligned    = dram_read_addr & {{(DRAM_ADDR_WIDTH-4){1'b1}}, 4'b0000};
    assign w_room       = 9'd256 - {1'b0, dram_read_addr[11:4]};
    // room modulo 256; exact whenever a split happens, since room <= len <= 255 then
    assign w_room_lo    = 8'd0 - dram_read_addr[11:4];
    // room - 1 == 255 - page beat index
    assign w_first_len  = ~dram_read_addr[11:4];
    // len + 1 <= room  <=>  len <= room - 1
    assign w_fits       = (dram_read_len <= w_first_len);
    assign w_second_len = dram_read_len - w_room_lo;
    // Full-width add: carries past bit 11 propagate and the top wraps modulo 2^W
    assign w_addr2      = w_aligned + {{(DRAM_ADDR_WIDTH-13){1'b0}}, w_room, 4'b0000};

    assign w_last_by_cnt = (beat_cnt_q == arlen_q);

    // State, burst bookkeeping and beat forwarding registers
    always_ff @(posedge clk_pixel) begin
        if (dram_read_master_reset) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            addr2_q      <= '0;
            len2_q       <= '0;
            split_q      <= 1'b0;
            beat_cnt_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            addr2_q      <= addr2_d;
            len2_q       <= len2_d;
            split_q      <= split_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic: accept in IDLE, issue AR, collect beats, optional second burst
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        addr2_d      = addr2_q;
        len2_d       = len2_q;
        split_d      = split_q;
        beat_cnt_d   = beat_cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (dram_read_en) begin
                    araddr_d   = w_aligned;
                    arlen_d    = w_fits ? dram_read_len : w_first_len;
                    split_d    = ~w_fits;
                    addr2_d    = w_addr2;
                    len2_d     = w_second_len;
                    beat_cnt_d = '0;
                    state_d    = ST_AR;
                end
            end

            ST_AR, ST_AR2: begin
                if (m_axi_arready) begin
                    beat_cnt_d = '0;
                    state_d    = (state_q == ST_AR) ? ST_R : ST_R2;
                end
            end

            ST_R, ST_R2: begin
                // rready is high in these states, so rvalid alone is a handshake
                if (m_axi_rvalid) begin
                    data_d       = m_axi_rdata;
                    data_valid_d = 1'b1;
                    // Bad response, or rlast out of step with our own beat count
                    if ((m_axi_rresp != C_RESP_OKAY) || (m_axi_rlast != w_last_by_cnt)) begin
                        error_d = 1'b1;
                    end
                    // Either indication ends the burst so a faulty slave cannot wedge us
                    if (w_last_by_cnt || m_axi_rlast) begin
                        if ((state_q == ST_R) && split_q) begin
                            araddr_d = addr2_q;
                            arlen_d  = len2_q;
                            state_d  = ST_AR2;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = C_ARSIZE;
    assign m_axi_arburst = C_ARBURST;
    assign m_axi_arvalid = (state_q == ST_AR) || (state_q == ST_AR2);
    assign m_axi_rready  = (state_q == ST_R)  || (state_q == ST_R2);

    assign dram_read_busy       = (state_q != ST_IDLE);
    assign dram_read_data       = data_q;
    assign dram_read_data_valid = data_valid_q;
    assign dram_read_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_read_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dram_read_master
// Brief    : Self-checking bench for dram_read_master. Acts as the AXI read
//            slave with random handshake gaps and random data; expected bursts
//            come from a page-arithmetic model of the 4 KB split rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_read_master;

    localparam int AW = 39;
    localparam int DW = 128;
    localparam logic [63:0] ADDR_MASK = (64'd1 << AW) - 64'd1;

    logic          clk_pixel = 1'b0;
    logic          rst;
    logic [AW-1:0] dram_read_addr;
    logic [7:0]    dram_read_len;
    logic          dram_read_en;
    logic          dram_read_busy;
    logic [DW-1:0] dram_read_data;
    logic          dram_read_data_valid;
    logic          dram_read_error;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int errors   = 0;
    int checks   = 0;
    int ar_count = 0;
    bit exp_err  = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    dram_read_master #(
        .DRAM_ADDR_WIDTH (AW),
        .DRAM_DATA_WIDTH (DW)
    ) dut (
        .clk_pixel              (clk_pixel),
        .dram_read_master_reset (rst),
        .dram_read_addr         (dram_read_addr),
        .dram_read_len          (dram_read_len),
        .dram_read_en           (dram_read_en),
        .dram_read_busy         (dram_read_busy),
        .dram_read_data         (dram_read_data),
        .dram_read_data_valid   (dram_read_data_valid),
        .dram_read_error        (dram_read_error),
        .m_axi_araddr           (m_axi_araddr),
        .m_axi_arlen            (m_axi_arlen),
        .m_axi_arsize           (m_axi_arsize),
        .m_axi_arburst          (m_axi_arburst),
        .m_axi_arvalid          (m_axi_arvalid),
        .m_axi_arready          (m_axi_arready),
        .m_axi_rdata            (m_axi_rdata),
        .m_axi_rresp            (m_axi_rresp),
        .m_axi_rlast            (m_axi_rlast),
        .m_axi_rvalid           (m_axi_rvalid),
        .m_axi_rready           (m_axi_rready)
    );

    // Count every AR handshake the DUT makes
    always @(posedge clk_pixel) begin
        if (m_axi_arvalid && m_axi_arready) ar_count <= ar_count + 1;
    end

    task automatic tick();
        @(negedge clk_pixel);
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete request. bad_beat: beat index (whole request) returning SLVERR.
    // early_at: beat index in the first burst carrying a premature rlast.
    // drop_last: final beat of the request comes without rlast.
    // poke_busy: fire a second request strobe while this one is in flight.
    task automatic run_req(input logic [AW-1:0] addr, input logic [7:0] len,
                           input int bad_beat, input int early_at,
                           input bit drop_last, input bit poke_busy);
        logic [63:0]   base;
        logic [63:0]   b_addr [2];
        int            b_len  [2];
        int            room;
        int            nb;
        int            ar_before;
        int            gidx;
        int            nbeats;
        int            cnt;
        int            dly;
        bit            last;
        bit            early_ok;
        logic [63:0]   rnd;
        logic [DW-1:0] beat_data;

        // Reference: beats left in the 4 KB page from the aligned start
        base = ({25'd0, addr} & ADDR_MASK) & ~64'hF;
        room = 256 - int'((base % 64'd4096) / 64'd16);
        b_addr[0] = base;
        b_addr[1] = 64'd0;
        b_len[1]  = 0;
        if (int'(len) + 1 <= room) begin
            nb       = 1;
            b_len[0] = int'(len);
        end else begin
            nb        = 2;
            b_len[0]  = room - 1;
            b_addr[1] = (base + 64'(room) * 64'd16) & ADDR_MASK;
            b_len[1]  = int'(len) - room;
        end
        early_ok = (early_at >= 0) && (early_at < b_len[0]);

        ar_before      = ar_count;
        dram_read_addr = addr;
        dram_read_len  = len;
        dram_read_en   = 1'b1;
        tick();
        dram_read_en   = 1'b0;
        check("busy_after_accept", {127'd0, dram_read_busy}, 128'd1);

        if (poke_busy) begin
            rnd            = {$urandom, $urandom};
            dram_read_addr = rnd[AW-1:0];
            dram_read_len  = 8'hFF;
            dram_read_en   = 1'b1;
            tick();
            dram_read_en   = 1'b0;
        end

        gidx = 0;
        for (int b = 0; b < nb; b++) begin
            cnt = 0;
            while (!m_axi_arvalid && cnt < 50) begin
                tick();
                cnt++;
            end
            check("ar_wait", {127'd0, m_axi_arvalid}, 128'd1);
            if (!m_axi_arvalid) return;
            check("araddr",   {89'd0, m_axi_araddr},  {89'd0, b_addr[b][AW-1:0]});
            check("arlen",    {120'd0, m_axi_arlen},  {120'd0, 8'(b_len[b])});
            check("arsize",   {125'd0, m_axi_arsize}, {125'd0, 3'b100});
            check("arburst",  {126'd0, m_axi_arburst}, {126'd0, 2'b01});
            check("rready_in_ar", {127'd0, m_axi_rready}, 128'd0);
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                tick();
                check("ar_hold", {88'd0, m_axi_arvalid, m_axi_araddr},
                      {88'd0, 1'b1, b_addr[b][AW-1:0]});
            end
            m_axi_arready = 1'b1;
            tick();
            m_axi_arready = 1'b0;

            nbeats = b_len[b] + 1;
            if (b == 0 && early_ok) nbeats = early_at + 1;

            for (int k = 0; k < nbeats; k++) begin
                dly = $urandom_range(0, 2);
                repeat (dly) begin
                    tick();
                    check("no_spurious_valid", {127'd0, dram_read_data_valid}, 128'd0);
                end
                check("rready_in_r", {127'd0, m_axi_rready}, 128'd1);
                beat_data    = {$urandom, $urandom, $urandom, $urandom};
                last         = (k == nbeats - 1);
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat_data;
                m_axi_rresp  = (gidx == bad_beat) ? 2'b10 : 2'b00;
                m_axi_rlast  = last && !(drop_last && b == nb - 1);
                if (gidx == bad_beat) exp_err = 1'b1;
                if (b == 0 && early_ok && last) exp_err = 1'b1;
                if (last && drop_last && b == nb - 1) exp_err = 1'b1;
                tick();
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                check("beat_valid", {127'd0, dram_read_data_valid}, 128'd1);
                check("beat_data", dram_read_data, beat_data);
                check("error_flag", {127'd0, dram_read_error}, {127'd0, exp_err});
                gidx++;
            end
            check("busy_after_burst", {127'd0, dram_read_busy},
                  (b == nb - 1) ? 128'd0 : 128'd1);
        end
        check("ar_count", 128'(ar_count - ar_before), 128'(nb));
    endtask

    initial begin
        logic [63:0] rnd;
        logic [7:0]  rlen;

        rst            = 1'b1;
        dram_read_addr = '0;
        dram_read_len  = '0;
        dram_read_en   = 1'b0;
        m_axi_arready  = 1'b0;
        m_axi_rdata    = '0;
        m_axi_rresp    = 2'b00;
        m_axi_rlast    = 1'b0;
        m_axi_rvalid   = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy",    {127'd0, dram_read_busy},       128'd0);
        check("rst_valid",   {127'd0, dram_read_data_valid}, 128'd0);
        check("rst_error",   {127'd0, dram_read_error},      128'd0);
        check("rst_arvalid", {127'd0, m_axi_arvalid},        128'd0);
        check("rst_rready",  {127'd0, m_axi_rready},         128'd0);
        check("rst_data",    dram_read_data,                 128'd0);
        rst = 1'b0;
        tick();

        // Plain single burst, page-crossing split, unaligned address, busy poke
        run_req(39'h1000, 8'd3, -1, -1, 1'b0, 1'b0);
        run_req(39'h1FC0, 8'd7, -1, -1, 1'b0, 1'b0);
        run_req(39'h100F, 8'd0, -1, -1, 1'b0, 1'b0);
        run_req(39'h2040, 8'd5, -1, -1, 1'b0, 1'b1);
        // Full 256-beat request from a page start, and one that splits at one beat
        run_req(39'h0_0000_3000, 8'd255, -1, -1, 1'b0, 1'b0);
        run_req(39'h0_0000_4FF0, 8'd2,   -1, -1, 1'b0, 1'b0);
        // Top of the address space: second burst wraps to 0
        run_req(39'h7F_FFFF_FFA0, 8'd15, -1, -1, 1'b0, 1'b0);

        // Error cases: SLVERR on beat 2, early rlast on beat 3, missing rlast
        run_req(39'h8000, 8'd3, 1, -1, 1'b0, 1'b0);
        run_req(39'h9000, 8'd3, -1, 2, 1'b0, 1'b0);
        run_req(39'hA000, 8'd2, -1, -1, 1'b1, 1'b0);
        check("error_held", {127'd0, dram_read_error}, 128'd1);

        // Reset in the middle of an R phase
        dram_read_addr = 39'hB000;
        dram_read_len  = 8'd7;
        dram_read_en   = 1'b1;
        tick();
        dram_read_en   = 1'b0;
        m_axi_arready  = 1'b1;
        tick();
        m_axi_arready  = 1'b0;
        m_axi_rvalid   = 1'b1;
        m_axi_rdata    = {$urandom, $urandom, $urandom, $urandom};
        tick();
        m_axi_rvalid   = 1'b0;
        check("mid_r_rready", {127'd0, m_axi_rready}, 128'd1);
        rst = 1'b1;
        tick();
        check("mr_arvalid", {127'd0, m_axi_arvalid},        128'd0);
        check("mr_rready",  {127'd0, m_axi_rready},         128'd0);
        check("mr_busy",    {127'd0, dram_read_busy},       128'd0);
        check("mr_valid",   {127'd0, dram_read_data_valid}, 128'd0);
        check("mr_error",   {127'd0, dram_read_error},      128'd0);
        check("mr_data",    dram_read_data,                 128'd0);
        exp_err = 1'b0;

        // Reset wins over a simultaneous request strobe
        dram_read_en = 1'b1;
        tick();
        rst          = 1'b0;
        dram_read_en = 1'b0;
        tick();
        tick();
        check("rst_vs_en_busy",    {127'd0, dram_read_busy}, 128'd0);
        check("rst_vs_en_arvalid", {127'd0, m_axi_arvalid},  128'd0);

        // Fresh request after reset completes normally
        run_req(39'hB000, 8'd7, -1, -1, 1'b0, 1'b0);

        // Random addresses and lengths
        for (int i = 0; i < 10; i++) begin
            rnd  = {$urandom, $urandom};
            rlen = 8'($urandom_range(0, 63));
            if (i % 3 == 0) rlen = 8'($urandom);
            run_req(rnd[AW-1:0], rlen, -1, -1, 1'b0, (i % 4 == 1));
        end
        check("final_error", {127'd0, dram_read_error}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
